// File: rtl/decode_stage_pkg.sv
// Shared core defines: RV32/64 opcodes, func3 codes, decoded control bundle.
// Latency: n/a (types, constants and a pure combinational decode function).
// Backpressure: n/a.
package decode_stage_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // func3 encodings with no defined instruction
  localparam logic [2:0] F3_BR_RSV_A = 3'b010;
  localparam logic [2:0] F3_BR_RSV_B = 3'b011;
  localparam logic [2:0] F3_LD_RSV_A = 3'b011;
  localparam logic [2:0] F3_LD_RSV_B = 3'b110;
  localparam logic [2:0] F3_LD_RSV_C = 3'b111;
  localparam logic [2:0] F3_ST_FIRST_RSV = 3'b011;

  typedef enum logic [2:0] {FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_e;
  typedef enum logic [1:0] {OP1_ZERO, OP1_RS1, OP1_PC, OP1_IMM} op1_sel_e;
  typedef enum logic [1:0] {OP2_ZERO, OP2_RS2, OP2_IMM, OP2_FOUR} op2_sel_e;
  typedef enum logic [1:0] {JOP_ZERO, JOP_PC, JOP_RS1} jop1_sel_e;
  typedef enum logic [1:0] {JOFF_ZERO, JOFF_IMM, JOFF_RS2} jop2_sel_e;

  // Decoded bundle in control form; the datapath turns the selects into values.
  typedef struct packed {
    imm_fmt_e  fmt;
    op1_sel_e  op1;
    op2_sel_e  op2;
    jop1_sel_e jop1;
    jop2_sel_e jop2;
    logic      use_rs1;
    logic      use_rs2;
    logic      writes_rd;
    logic      illegal;
  } dec_ctrl_t;

  function automatic dec_ctrl_t decode_ctrl(input logic [31:0] instr);
    dec_ctrl_t c;
    logic [2:0] f3;
    f3 = instr[14:12];
    c  = '0;
    case (instr[6:0])
      OPC_OP_IMM: begin
        c.fmt = FMT_I; c.op1 = OP1_RS1; c.op2 = OP2_IMM;
        c.use_rs1 = 1'b1; c.writes_rd = 1'b1;
      end
      OPC_LOAD: begin
        if (f3 == F3_LD_RSV_A || f3 == F3_LD_RSV_B || f3 == F3_LD_RSV_C) begin
          c.illegal = 1'b1;
        end else begin
          c.fmt = FMT_I; c.op1 = OP1_RS1; c.op2 = OP2_IMM;
          c.use_rs1 = 1'b1; c.writes_rd = 1'b1;
        end
      end
      OPC_OP: begin
        c.op1 = OP1_RS1; c.op2 = OP2_RS2;
        c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; c.writes_rd = 1'b1;
      end
      OPC_STORE: begin
        if (f3 >= F3_ST_FIRST_RSV) begin
          c.illegal = 1'b1;
        end else begin
          c.fmt = FMT_S; c.op1 = OP1_RS1; c.op2 = OP2_IMM; c.jop2 = JOFF_RS2;
          c.use_rs1 = 1'b1; c.use_rs2 = 1'b1;
        end
      end
      OPC_BRANCH: begin
        if (f3 == F3_BR_RSV_A || f3 == F3_BR_RSV_B) begin
          c.illegal = 1'b1;
        end else begin
          c.fmt = FMT_B; c.op1 = OP1_RS1; c.op2 = OP2_RS2;
          c.jop1 = JOP_PC; c.jop2 = JOFF_IMM;
          c.use_rs1 = 1'b1; c.use_rs2 = 1'b1;
        end
      end
      OPC_LUI: begin
        c.fmt = FMT_U; c.op1 = OP1_IMM; c.writes_rd = 1'b1;
      end
      OPC_AUIPC: begin
        c.fmt = FMT_U; c.op1 = OP1_PC; c.op2 = OP2_IMM; c.writes_rd = 1'b1;
      end
      OPC_JAL: begin
        c.fmt = FMT_J; c.op1 = OP1_PC; c.op2 = OP2_FOUR;
        c.jop1 = JOP_PC; c.jop2 = JOFF_IMM; c.writes_rd = 1'b1;
      end
      OPC_JALR: begin
        c.fmt = FMT_I; c.op1 = OP1_PC; c.op2 = OP2_FOUR;
        c.jop1 = JOP_RS1; c.jop2 = JOFF_IMM;
        c.use_rs1 = 1'b1; c.writes_rd = 1'b1;
      end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode, register-file read and decode-to-execute signal bundle.
// Latency: n/a (wiring only); slave modport is the decode stage's view.
// Backpressure: valid/ready on both the fetch side and the execute side.
interface decode_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [XLEN-1:0]       in_instr_addr;
  logic [31:0]           in_instr;
  logic [REG_ADDR_W-1:0] reg1_addr;
  logic [REG_ADDR_W-1:0] reg2_addr;
  logic [XLEN-1:0]       reg1_data;
  logic [XLEN-1:0]       reg2_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       out_instr_addr;
  logic [31:0]           out_instr;
  logic [XLEN-1:0]       out_op1;
  logic [XLEN-1:0]       out_op2;
  logic [XLEN-1:0]       out_jump_op1;
  logic [XLEN-1:0]       out_jump_op2;
  logic [REG_ADDR_W-1:0] out_write_addr;
  logic                  out_wen;
  logic                  out_illegal;

  modport slave (
    input  in_valid, in_instr_addr, in_instr, reg1_data, reg2_data, out_ready,
    output in_ready, reg1_addr, reg2_addr, out_valid, out_instr_addr, out_instr,
           out_op1, out_op2, out_jump_op1, out_jump_op2, out_write_addr, out_wen, out_illegal
  );

  modport master (
    output in_valid, in_instr_addr, in_instr, reg1_data, reg2_data, out_ready,
    input  in_ready, reg1_addr, reg2_addr, out_valid, out_instr_addr, out_instr,
           out_op1, out_op2, out_jump_op1, out_jump_op2, out_write_addr, out_wen, out_illegal
  );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// Immediate extraction: picks the I/S/B/U/J field and sign-extends to XLEN.
// Latency: combinational.
// Backpressure: none.
module imm_gen
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);
  logic signed [31:0] raw;
  // The opcode field carries no immediate bits.
  logic unused_opc;
  assign unused_opc = ^instr[6:0];

  // Assemble the 32-bit immediate, then sign-extend to the datapath width.
  always_comb begin
    raw = '0;
    case (fmt)
      FMT_I:   raw = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   raw = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   raw = {instr[31:12], 12'b0};
      FMT_J:   raw = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: raw = '0;
    endcase
    imm = XLEN'(raw);
  end
endmodule

// File: rtl/decode_stage.sv
// Decode stage: reads rs1/rs2, builds ALU/jump operands, registers the bundle.
// Latency: 1 cycle accept-to-out_valid; DECODE_SKID_BUF_EN adds a one-entry skid with registered in_ready.
// Backpressure: outputs held while out_valid && !out_ready; in_ready drops while the output is full.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  decode_stage_if.slave   bus
);
  localparam int BW = 5 * XLEN + 32 + REG_ADDR_W + 2;

  dec_ctrl_t             ctrl;
  logic [XLEN-1:0]       imm;
  logic [XLEN-1:0]       op1_d, op2_d, jop1_d, jop2_d;
  logic [REG_ADDR_W-1:0] rd, waddr_d;
  logic                  wen_d;
  logic [BW-1:0]         bundle_d, main_q;
  logic                  out_vld_q;

  assign ctrl = decode_ctrl(bus.in_instr);

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (bus.in_instr),
    .fmt   (ctrl.fmt),
    .imm   (imm)
  );

  // Register-file read addresses only toggle for instructions that read them.
  assign bus.reg1_addr = ctrl.use_rs1 ? REG_ADDR_W'(bus.in_instr[19:15]) : '0;
  assign bus.reg2_addr = ctrl.use_rs2 ? REG_ADDR_W'(bus.in_instr[24:20]) : '0;

  assign rd      = REG_ADDR_W'(bus.in_instr[11:7]);
  assign wen_d   = ctrl.writes_rd && (rd != '0);
  assign waddr_d = wen_d ? rd : '0;

  // Turn operand selects into values; unselected operands are zero.
  always_comb begin
    op1_d  = '0;
    op2_d  = '0;
    jop1_d = '0;
    jop2_d = '0;
    case (ctrl.op1)
      OP1_RS1: op1_d = bus.reg1_data;
      OP1_PC:  op1_d = bus.in_instr_addr;
      OP1_IMM: op1_d = imm;
      default: op1_d = '0;
    endcase
    case (ctrl.op2)
      OP2_RS2:  op2_d = bus.reg2_data;
      OP2_IMM:  op2_d = imm;
      OP2_FOUR: op2_d = XLEN'(4);
      default:  op2_d = '0;
    endcase
    case (ctrl.jop1)
      JOP_PC:  jop1_d = bus.in_instr_addr;
      JOP_RS1: jop1_d = bus.reg1_data;
      default: jop1_d = '0;
    endcase
    case (ctrl.jop2)
      JOFF_IMM: jop2_d = imm;
      JOFF_RS2: jop2_d = bus.reg2_data;
      default:  jop2_d = '0;
    endcase
  end

  assign bundle_d = {bus.in_instr_addr, bus.in_instr, op1_d, op2_d, jop1_d, jop2_d,
                     waddr_d, wen_d, ctrl.illegal};

  assign {bus.out_instr_addr, bus.out_instr, bus.out_op1, bus.out_op2, bus.out_jump_op1,
          bus.out_jump_op2, bus.out_write_addr, bus.out_wen, bus.out_illegal} = main_q;
  assign bus.out_valid = out_vld_q;

`ifdef DECODE_SKID_BUF_EN
  logic [BW-1:0] skid_q;
  logic          skid_vld_q;
  logic          rdy_q;
  logic          take;

  assign bus.in_ready = rdy_q;
  assign take         = bus.in_valid && rdy_q;

  // Output register plus one skid entry; register data is captured decoded
  // because the register file only presents it in the accept cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else if (flush) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b1;
    end else if (!out_vld_q || bus.out_ready) begin
      if (skid_vld_q) begin
        main_q     <= skid_q;
        out_vld_q  <= 1'b1;
        skid_vld_q <= 1'b0;
      end else begin
        out_vld_q <= take;
        if (take) main_q <= bundle_d;
      end
      rdy_q <= 1'b1;
    end else if (take) begin
      skid_q     <= bundle_d;
      skid_vld_q <= 1'b1;
      rdy_q      <= 1'b0;
    end
  end
`else
  assign bus.in_ready = !out_vld_q || bus.out_ready;

  // Single output register: load whenever the slot is empty or draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      main_q    <= '0;
    end else if (flush) begin
      out_vld_q <= 1'b0;
    end else if (bus.in_ready) begin
      out_vld_q <= bus.in_valid;
      if (bus.in_valid) main_q <= bundle_d;
    end
  end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with an expected-bundle scoreboard.
module tb_decode_stage;
  typedef struct packed {
    logic [31:0] pc, ins, op1, op2, j1, j2;
    logic [4:0]  wa;
    logic        wen, ill;
  } exp_t;

`ifdef DECODE_SKID_BUF_EN
  localparam int SKID_EXP = 1;
`else
  localparam int SKID_EXP = 0;
`endif

  logic clk, rst, flush;
  decode_stage_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();
  decode_stage_if #(.XLEN(64), .REG_ADDR_W(5)) bus64 ();

  decode_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));
  decode_stage #(.XLEN(64), .REG_ADDR_W(5)) dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(bus64));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file model: xN holds N*10.
  function automatic logic [31:0] rf(input logic [4:0] a);
    return 32'(a) * 32'd10;
  endfunction

  always_comb begin
    bus.reg1_data = rf(bus.reg1_addr);
    bus.reg2_data = rf(bus.reg2_addr);
  end
  assign bus64.reg1_data = '0;
  assign bus64.reg2_data = '0;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_out    = 0;
  exp_t sb[$];
  exp_t pend;
  logic acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  function automatic exp_t mk(input logic [31:0] pc, ins, op1, op2, j1, j2,
                              input logic [4:0] wa, input logic wen, ill);
    exp_t e;
    e = '{pc: pc, ins: ins, op1: op1, op2: op2, j1: j1, j2: j2, wa: wa, wen: wen, ill: ill};
    return e;
  endfunction

  task automatic check_out(input exp_t e);
    string s;
    s = $sformatf("[%0d]", n_out);
    chk({"pc", s},    bus.out_instr_addr, e.pc);
    chk({"instr", s}, bus.out_instr,      e.ins);
    chk({"op1", s},   bus.out_op1,        e.op1);
    chk({"op2", s},   bus.out_op2,        e.op2);
    chk({"jop1", s},  bus.out_jump_op1,   e.j1);
    chk({"jop2", s},  bus.out_jump_op2,   e.j2);
    chk({"waddr", s}, bus.out_write_addr, e.wa);
    chk({"wen", s},   bus.out_wen,        e.wen);
    chk({"ill", s},   bus.out_illegal,    e.ill);
    n_out++;
  endtask

  // One clock: score an output transfer, record an input transfer.
  task automatic tick();
    @(negedge clk);
    if (bus.out_valid && bus.out_ready) begin
      n_checks = n_checks + 1;
      assert (sb.size() != 0) n_pass = n_pass + 1;
      else $error("FAIL sb_underflow: got unexpected output instr 0x%0h, want none", bus.out_instr);
      if (sb.size() != 0) check_out(sb.pop_front());
    end
    acc = bus.in_valid && bus.in_ready && !flush;
    if (acc) sb.push_back(pend);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pc, ins, input logic [4:0] r1, r2, input exp_t e);
    bus.in_valid = 1'b1;
    bus.in_instr_addr = pc;
    bus.in_instr = ins;
    pend = e;
    #1;
    chk($sformatf("rs1_addr_%h", ins), bus.reg1_addr, r1);
    chk($sformatf("rs2_addr_%h", ins), bus.reg2_addr, r2);
    acc = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (acc) break;
    end
    chk($sformatf("accepted_%h", ins), acc, 1'b1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (sb.size() == 0 && !bus.out_valid) break;
      tick();
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  int n_acc;

  initial begin
    rst = 1'b1; flush = 1'b0; acc = 1'b0; pend = '0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_instr_addr = '0; bus.out_ready = 1'b0;
    bus64.in_valid = 1'b0; bus64.in_instr = '0; bus64.in_instr_addr = '0; bus64.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_op1",   bus.out_op1, 0);
    chk("rst_instr", bus.out_instr, 0);
    chk("rst_wen",   bus.out_wen, 1'b0);
    chk("rst_ill",   bus.out_illegal, 1'b0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ready_after_rst", bus.in_ready, 1'b1);

    bus.out_ready = 1'b1;
    send(32'h0, 32'hFFF08293, 5'd1, 5'd0, mk(32'h0, 32'hFFF08293, 32'd10, 32'hFFFFFFFF, 0, 0, 5'd5, 1, 0));
    chk("latency_valid", bus.out_valid, 1'b1);
    send(32'h100, 32'hFE208CE3, 5'd1, 5'd2, mk(32'h100, 32'hFE208CE3, 32'd10, 32'd20, 32'h100, 32'hFFFFFFF8, 0, 0, 0));
    send(32'h104, 32'h123451B7, 5'd0, 5'd0, mk(32'h104, 32'h123451B7, 32'h12345000, 0, 0, 0, 5'd3, 1, 0));
    send(32'h200, 32'h00001217, 5'd0, 5'd0, mk(32'h200, 32'h00001217, 32'h200, 32'h1000, 0, 0, 5'd4, 1, 0));
    send(32'h300, 32'h010000EF, 5'd0, 5'd0, mk(32'h300, 32'h010000EF, 32'h300, 32'd4, 32'h300, 32'd16, 5'd1, 1, 0));
    send(32'h400, 32'h00410067, 5'd2, 5'd0, mk(32'h400, 32'h00410067, 32'h400, 32'd4, 32'd20, 32'd4, 0, 0, 0));
    send(32'h404, 32'hFE20AE23, 5'd1, 5'd2, mk(32'h404, 32'hFE20AE23, 32'd10, 32'hFFFFFFFC, 0, 32'd20, 0, 0, 0));
    send(32'h408, 32'h00208333, 5'd1, 5'd2, mk(32'h408, 32'h00208333, 32'd10, 32'd20, 0, 0, 5'd6, 1, 0));
    send(32'h40C, 32'h00812383, 5'd2, 5'd0, mk(32'h40C, 32'h00812383, 32'd20, 32'd8, 0, 0, 5'd7, 1, 0));
    send(32'h410, 32'h000002FF, 5'd0, 5'd0, mk(32'h410, 32'h000002FF, 0, 0, 0, 0, 0, 0, 1));
    send(32'h414, 32'h0020A063, 5'd0, 5'd0, mk(32'h414, 32'h0020A063, 0, 0, 0, 0, 0, 0, 1));
    send(32'h418, 32'h0000B283, 5'd0, 5'd0, mk(32'h418, 32'h0000B283, 0, 0, 0, 0, 0, 0, 1));
    send(32'h41C, 32'h0020B023, 5'd0, 5'd0, mk(32'h41C, 32'h0020B023, 0, 0, 0, 0, 0, 0, 1));
    send(32'h420, 32'h00100013, 5'd0, 5'd0, mk(32'h420, 32'h00100013, 0, 32'd1, 0, 0, 0, 0, 0));
    drain();

    // Stall: hold out_ready low for 3 cycles while fetch keeps offering.
    send(32'h500, 32'h00208333, 5'd1, 5'd2, mk(32'h500, 32'h00208333, 32'd10, 32'd20, 0, 0, 5'd6, 1, 0));
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr_addr = 32'h504; bus.in_instr = 32'hFFF08293;
    pend = mk(32'h504, 32'hFFF08293, 32'd10, 32'hFFFFFFFF, 0, 0, 5'd5, 1, 0);
    n_acc = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (acc) begin
        n_acc++;
        bus.in_valid = 1'b0;
      end
      chk($sformatf("stall_valid_%0d", k), bus.out_valid, 1'b1);
      chk($sformatf("stall_instr_%0d", k), bus.out_instr, 32'h00208333);
      chk($sformatf("stall_op2_%0d", k), bus.out_op2, 32'd20);
      chk($sformatf("stall_pc_%0d", k), bus.out_instr_addr, 32'h500);
    end
    chk("stall_accepts", n_acc, SKID_EXP);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (n_acc != 0) break;
      tick();
      if (acc) n_acc++;
    end
    bus.in_valid = 1'b0;
    chk("stall_b_once", n_acc, 1);
    drain();

    // Flush with a held bundle and a new offer in the same cycle.
    send(32'h600, 32'h123451B7, 5'd0, 5'd0, mk(32'h600, 32'h123451B7, 32'h12345000, 0, 0, 0, 5'd3, 1, 0));
    bus.out_ready = 1'b0;
    flush = 1'b1;
    bus.in_valid = 1'b1; bus.in_instr_addr = 32'h604; bus.in_instr = 32'h00001217;
    sb.delete();
    tick();
    chk("flush_valid", bus.out_valid, 1'b0);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("flush_dropped", bus.out_valid, 1'b0);
    drain();

    // Reset in the middle of a stall.
    bus.out_ready = 1'b0;
    send(32'h700, 32'h010000EF, 5'd0, 5'd0, mk(32'h700, 32'h010000EF, 32'h700, 32'd4, 32'h700, 32'd16, 5'd1, 1, 0));
    tick();
    chk("pre_rst_valid", bus.out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", bus.out_valid, 1'b0);
    chk("async_rst_op1", bus.out_op1, 0);
    chk("async_rst_instr", bus.out_instr, 0);
    sb.delete();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ready_after_rst2", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;

    // XLEN=64 sign extension of a U-immediate.
    bus64.out_ready = 1'b1;
    bus64.in_valid = 1'b1; bus64.in_instr_addr = 64'h40; bus64.in_instr = 32'h800000B7;
    @(posedge clk);
    #1;
    bus64.in_valid = 1'b0;
    chk("x64_valid", bus64.out_valid, 1'b1);
    chk("x64_lui_op1", bus64.out_op1, 64'hFFFFFFFF80000000);
    chk("x64_lui_op2", bus64.out_op2, 0);
    chk("x64_wen", bus64.out_wen, 1'b1);
    chk("x64_waddr", bus64.out_write_addr, 5'd1);

    drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
